vx_alu_int_pipe: RTL
====================

VX_ALU_INT_PIPE -- requirements
Module: VX_alu_int_pipe

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, SIMD lanes per issue.
REQ-002 SHALL have parameter XLEN, default 32, operand and PC width (byte PC).
REQ-003 SHALL have parameter LATENCY, default 2, pipeline stages (legal 1..4).
REQ-004 SHALL have parameter TAG_W, default 8, opaque sideband (uuid/wid/rd) width.
REQ-005 SHALL have ports: clk input 1, clock; reset_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: in_valid input 1; in_ready output 1; in_op input 4, opcode; in_is_br input 1, branch class; in_use_imm input 1; in_use_pc input 1; in_imm input XLEN; in_pc input XLEN; in_tid input max(1,clog2(NUM_LANES)), branch lane; in_eop input 1; in_tag input TAG_W; in_rs1, in_rs2 input NUM_LANES*XLEN.
REQ-007 SHALL have ports: out_valid output 1; out_ready input 1; out_data output NUM_LANES*XLEN; out_tag output TAG_W; out_pc output XLEN.
REQ-008 SHALL have ports: br_valid output 1; br_taken output 1; br_dest output XLEN; br_tag output TAG_W.

Function
REQ-009 ALU ops (in_is_br=0): 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 SRL, 5 SRA, 6 AND, 7 OR, 8 XOR, 9 SLL, 10 CZERO_EQZ, 11 CZERO_NEZ; 12-15 SHALL yield 0.
REQ-010 Operand B SHALL be in_imm when in_use_imm, else rs2; operand A SHALL be in_pc for ADD when in_use_pc, else rs1.
REQ-011 Shift amount SHALL be B[clog2(XLEN)-1:0]; SLT/SLTU result SHALL be zero-extended 1-bit compare; ADD/SUB wrap modulo 2^XLEN.
REQ-012 Branch ops (in_is_br=1): 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR; compare uses rs1 vs rs2 (never imm) of lane in_tid.
REQ-013 Branch dest SHALL be in_pc+in_imm for conditional/JAL; JALR SHALL be (rs1[tid]+in_imm) with bit 0 cleared.
REQ-014 JAL/JALR SHALL write in_pc+4 to every lane's out_data; conditional branches write 0.
REQ-015 Datapath SHALL be computed in stage 0 and carried through LATENCY register stages; out_* SHALL appear exactly LATENCY cycles after in fire when never stalled.
REQ-016 Each stage SHALL advance when next stage empty or advancing; in_ready = ~stage0_valid | stage0_advance (combinational from out_ready allowed).
REQ-017 Throughput SHALL be one op/cycle under out_ready=1; no op lost or duplicated under any out_ready pattern.
REQ-018 out_data/out_tag/out_pc SHALL hold stable while out_valid & ~out_ready.
REQ-019 On output fire of a branch op with eop=1, br_valid SHALL pulse 1 cycle the next cycle with br_taken, br_dest, br_tag registered; JAL/JALR always taken.
REQ-020 Branch ops with eop=0 SHALL write back but never assert br_valid.
REQ-021 Back-to-back branch fires SHALL produce back-to-back br_valid pulses.

Reset
REQ-022 reset_n low SHALL asynchronously clear all stage valids, out_valid, br_valid, br_taken to 0; data registers need not reset.
REQ-023 Reset mid-operation SHALL discard all in-flight ops; in_ready SHALL be 1 first cycle after deassertion.

Configuration
REQ-024 With ALU_INT_ZICOND_EN defined, ops 10/11 SHALL compute CZERO_EQZ: rs1 if rs2!=0 else 0; CZERO_NEZ: rs1 if rs2==0 else 0.
REQ-025 Without ALU_INT_ZICOND_EN, ops 10/11 SHALL yield 0 and no CZERO logic SHALL be synthesized.

Verification
REQ-026 LATENCY=2, ADD rs1=5, rs2=7 all lanes, out_ready=1 -> out_valid at cycle +2, every lane 12.
REQ-027 SRA rs1=0x80000000, imm=4, use_imm -> 0xF8000000; SRL same -> 0x08000000.
REQ-028 BLT tid=2, lane2 rs1=-1, rs2=1, pc=0x100, imm=0x20, eop=1 -> br_valid one cycle after out fire, taken=1, dest=0x120.
REQ-029 JALR pc=0x200, rs1[tid]=0x1001, imm=4 -> dest=0x1004, taken=1, all lanes out_data=0x204.
REQ-030 Stream 10 ops, out_ready toggled random 50% -> all 10 results in order, no drop/duplicate, outputs stable while stalled.
REQ-031 reset_n pulsed low with 2 ops in flight -> out_valid, br_valid 0 immediately; no stale output after release.

Source files
------------

// File: rtl/vx_alu_int_pipe.sv
// SIMD integer ALU + branch unit, LATENCY register stages, valid/ready with full-throughput skid-free pipeline.
// Optional Zicond ops (CZERO_EQZ/CZERO_NEZ) enabled by defining ALU_INT_ZICOND_EN.
module vx_alu_int_pipe #(
  parameter int NUM_LANES = 4,
  parameter int XLEN      = 32,
  parameter int LATENCY   = 2,
  parameter int TAG_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                in_op,
  input  logic                      in_is_br,
  input  logic                      in_use_imm,
  input  logic                      in_use_pc,
  input  logic [XLEN-1:0]           in_imm,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] in_tid,
  input  logic                      in_eop,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [NUM_LANES*XLEN-1:0] in_rs1,
  input  logic [NUM_LANES*XLEN-1:0] in_rs2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_LANES*XLEN-1:0] out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic [XLEN-1:0]           out_pc,
  output logic                      br_valid,
  output logic                      br_taken,
  output logic [XLEN-1:0]           br_dest,
  output logic [TAG_W-1:0]          br_tag
);

  localparam int SHW  = $clog2(XLEN);
  localparam int LAST = LATENCY - 1;

  typedef struct packed {
    logic [NUM_LANES*XLEN-1:0] data;
    logic [TAG_W-1:0]          tag;
    logic [XLEN-1:0]           pc;
    logic                      is_br;
    logic                      eop;
    logic                      taken;
    logic [XLEN-1:0]           dest;
  } pay_t;

  function automatic logic [XLEN-1:0] alu_op(input logic [3:0] op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      4'd0:    alu_op = a + b;
      4'd1:    alu_op = a - b;
      4'd2:    alu_op = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      4'd3:    alu_op = {{(XLEN-1){1'b0}}, a < b};
      4'd4:    alu_op = a >> sh;
      4'd5:    alu_op = $unsigned($signed(a) >>> sh);
      4'd6:    alu_op = a & b;
      4'd7:    alu_op = a | b;
      4'd8:    alu_op = a ^ b;
      4'd9:    alu_op = a << sh;
      default: alu_op = '0;
    endcase
  endfunction

  pay_t            nxt;
  logic [XLEN-1:0] br_a, br_b, jalr_sum, link;
  logic            br_cond, is_jump;

  always_comb begin
    br_a     = in_rs1[in_tid*XLEN +: XLEN];
    br_b     = in_rs2[in_tid*XLEN +: XLEN];
    jalr_sum = br_a + in_imm;
    link     = in_pc + XLEN'(4);
    is_jump  = (in_op == 4'd6) || (in_op == 4'd7);
    case (in_op)
      4'd0:       br_cond = (br_a == br_b);
      4'd1:       br_cond = (br_a != br_b);
      4'd2:       br_cond = ($signed(br_a) <  $signed(br_b));
      4'd3:       br_cond = ($signed(br_a) >= $signed(br_b));
      4'd4:       br_cond = (br_a <  br_b);
      4'd5:       br_cond = (br_a >= br_b);
      4'd6, 4'd7: br_cond = 1'b1;
      default:    br_cond = 1'b0;
    endcase

    nxt       = '0;
    nxt.tag   = in_tag;
    nxt.pc    = in_pc;
    nxt.is_br = in_is_br;
    nxt.eop   = in_eop;
    nxt.taken = in_is_br & br_cond;
    nxt.dest  = (in_op == 4'd7) ? {jalr_sum[XLEN-1:1], 1'b0} : (in_pc + in_imm);
    for (int l = 0; l < NUM_LANES; l++) begin
      if (in_is_br) begin
        nxt.data[l*XLEN +: XLEN] = is_jump ? link : '0;
      end else begin
        nxt.data[l*XLEN +: XLEN] = alu_op(in_op,
            (in_op == 4'd0 && in_use_pc) ? in_pc : in_rs1[l*XLEN +: XLEN],
            in_use_imm ? in_imm : in_rs2[l*XLEN +: XLEN]);
`ifdef ALU_INT_ZICOND_EN
        // Zicond tests rs2 itself, independent of in_use_imm.
        if (in_op == 4'd10)
          nxt.data[l*XLEN +: XLEN] = (in_rs2[l*XLEN +: XLEN] != '0) ? in_rs1[l*XLEN +: XLEN] : '0;
        else if (in_op == 4'd11)
          nxt.data[l*XLEN +: XLEN] = (in_rs2[l*XLEN +: XLEN] == '0) ? in_rs1[l*XLEN +: XLEN] : '0;
`endif
      end
    end
  end

  pay_t               pipe_q  [LATENCY];
  pay_t               src_pay [LATENCY];
  logic [LATENCY-1:0] vld_q, src_vld, rdy;

  assign src_vld[0] = in_valid;
  assign src_pay[0] = nxt;

  // A stage can load if the output drains or any bubble exists at or after it.
  for (genvar g = 0; g < LATENCY; g++) begin : gen_stage
    assign rdy[g] = out_ready | ~(&vld_q[LAST:g]);
    if (g > 0) begin : gen_link
      assign src_vld[g] = vld_q[g-1];
      assign src_pay[g] = pipe_q[g-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++)
        if (rdy[i]) vld_q[i] <= src_vld[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LATENCY; i++)
      if (rdy[i]) pipe_q[i] <= src_pay[i];
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[LAST];
  assign out_data  = pipe_q[LAST].data;
  assign out_tag   = pipe_q[LAST].tag;
  assign out_pc    = pipe_q[LAST].pc;

  logic br_fire;
  assign br_fire = out_valid & out_ready & pipe_q[LAST].is_br & pipe_q[LAST].eop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_valid <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      br_valid <= br_fire;
      if (br_fire) br_taken <= pipe_q[LAST].taken;
    end
  end

  always_ff @(posedge clk) begin
    if (br_fire) begin
      br_dest <= pipe_q[LAST].dest;
      br_tag  <= pipe_q[LAST].tag;
    end
  end

endmodule
